// File: rtl/dmac_rf_pkg.sv
// Shared constants, clear-FSM state type and byte parity helper for the DMAC register file.
package dmac_rf_pkg;

  localparam int unsigned RF_DATA_W = 32'd32;
  localparam int unsigned RF_DEPTH  = 32'd16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] data_byte);
    return ^data_byte;
  endfunction

endpackage

// File: rtl/dmac_rf_read_port.sv
// One registered read port: write-first bypass mux, output register and, when
// DMAC_RF_PARITY_EN is defined, a per-byte parity check on the selected entry.
module dmac_rf_read_port
  import dmac_rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned AW     = 32'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef DMAC_RF_PARITY_EN
  input  logic [DATA_W/8-1:0] mem_par,
  input  logic [DATA_W/8-1:0] wr_par,
`endif
  output logic [DATA_W-1:0] rd,
  output logic              rvalid,
  output logic              rperr
);

  logic              hit_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] rd_r;
  logic              rvalid_r;

  assign hit_s = wr_en && (wr_addr == ra);

  // Bypass: a same-cycle write (or clear) to the read address wins over storage.
  always_comb begin
    if (hit_s) begin
      sel_data_s = wr_data;
    end else begin
      sel_data_s = mem_data;
    end
  end

  // Read data holds between requests; valid pulses once per request.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_r     <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= re;
      if (re) begin
        rd_r <= sel_data_s;
      end
    end
  end

  assign rd     = rd_r;
  assign rvalid = rvalid_r;

`ifdef DMAC_RF_PARITY_EN
  localparam int unsigned NB = DATA_W / 8;

  logic [NB-1:0] sel_par_s;
  logic [NB-1:0] calc_par_s;
  logic          rperr_r;

  // Recompute parity of the selected data and compare against the stored bits.
  always_comb begin
    calc_par_s = '0;
    if (hit_s) begin
      sel_par_s = wr_par;
    end else begin
      sel_par_s = mem_par;
    end
    for (int unsigned b = 0; b < NB; b++) begin
      calc_par_s[b] = byte_parity(sel_data_s[8*b +: 8]);
    end
  end

  // Error flag is only meaningful alongside rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rperr_r <= 1'b0;
    end else begin
      rperr_r <= re && (|(sel_par_s ^ calc_par_s));
    end
  end

  assign rperr = rperr_r;
`else
  assign rperr = 1'b0;
`endif

endmodule

// File: rtl/dmac_regfile_multi.sv
// DMAC register file: byte-masked write port, two registered read ports and a
// sequential clear engine. Define DMAC_RF_PARITY_EN to add per-byte parity.
module dmac_regfile_multi
  import dmac_rf_pkg::*;
#(
  parameter  int unsigned DATA_W = RF_DATA_W,
  parameter  int unsigned DEPTH  = RF_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     wbe,
  output logic              wready,
  input  logic              re0,
  input  logic              re1,
  input  logic [AW-1:0]     ra0,
  input  logic [AW-1:0]     ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rperr0,
  output logic              rperr1,
  input  logic              clr_req,
  output logic              busy
);

  rf_state_e         state_r;
  rf_state_e         state_nxt_s;
  logic [AW-1:0]     cnt_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] old_data_s;
  logic              busy_s;
  logic              wr_en_s;
  logic [AW-1:0]     wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  assign old_data_s = mem_r[waddr];

  // Clear FSM state and entry pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_CLEAR) begin
        cnt_r <= cnt_r + AW'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Next state: clr_req only matters in IDLE; CLEAR ends after the last entry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) state_nxt_s = ST_CLEAR;
        else         state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_r == AW'(DEPTH - 1)) state_nxt_s = ST_IDLE;
        else                         state_nxt_s = ST_CLEAR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Single storage write path: merged user write in IDLE, zeroing in CLEAR.
  always_comb begin
    busy_s    = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = waddr;
    wr_data_s = old_data_s;
    case (state_r)
      ST_IDLE: begin
        busy_s    = 1'b0;
        wr_en_s   = we && (|wbe);
        wr_addr_s = waddr;
        for (int unsigned b = 0; b < NB; b++) begin
          if (wbe[b]) wr_data_s[8*b +: 8] = wdata[8*b +: 8];
          else        wr_data_s[8*b +: 8] = old_data_s[8*b +: 8];
        end
      end
      ST_CLEAR: begin
        busy_s    = 1'b1;
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_r;
        wr_data_s = '0;
      end
      default: begin
        busy_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = waddr;
        wr_data_s = old_data_s;
      end
    endcase
  end

  assign busy   = busy_s;
  assign wready = !busy_s;

  // Data storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

`ifdef DMAC_RF_PARITY_EN
  logic [NB-1:0] par_r [DEPTH];
  logic [NB-1:0] wr_par_s;

  // Parity is taken from the merged data, so untouched bytes stay consistent.
  always_comb begin
    wr_par_s = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      wr_par_s[b] = byte_parity(wr_data_s[8*b +: 8]);
    end
  end

  // Parity storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) par_r[i] <= '0;
    end else if (wr_en_s) begin
      par_r[wr_addr_s] <= wr_par_s;
    end
  end
`endif

  dmac_rf_read_port #(.DATA_W(DATA_W), .AW(AW)) u_rport0 (
    .clk      (clk),
    .reset    (reset),
    .re       (re0),
    .ra       (ra0),
    .mem_data (mem_r[ra0]),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_addr_s),
    .wr_data  (wr_data_s),
`ifdef DMAC_RF_PARITY_EN
    .mem_par  (par_r[ra0]),
    .wr_par   (wr_par_s),
`endif
    .rd       (rd0),
    .rvalid   (rvalid0),
    .rperr    (rperr0)
  );

  dmac_rf_read_port #(.DATA_W(DATA_W), .AW(AW)) u_rport1 (
    .clk      (clk),
    .reset    (reset),
    .re       (re1),
    .ra       (ra1),
    .mem_data (mem_r[ra1]),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_addr_s),
    .wr_data  (wr_data_s),
`ifdef DMAC_RF_PARITY_EN
    .mem_par  (par_r[ra1]),
    .wr_par   (wr_par_s),
`endif
    .rd       (rd1),
    .rvalid   (rvalid1),
    .rperr    (rperr1)
  );

endmodule

// File: tb/tb_dmac_regfile_multi.sv
// Self-checking bench for dmac_regfile_multi: directed scenarios plus a random
// phase checked against an array-based model of the register file contents.
module tb_dmac_regfile_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        wready;
  logic        re0, re1;
  logic [3:0]  ra0, ra1;
  logic [31:0] rd0, rd1;
  logic        rvalid0, rvalid1;
  logic        rperr0, rperr1;
  logic        clr_req;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [16];
  logic [31:0] exp0, exp1, last0, last1;
  logic        exp_perr;

  dmac_regfile_multi dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .wready(wready), .re0(re0), .re1(re1), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rperr0(rperr0), .rperr1(rperr1),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Byte-lane mask arithmetic: selected lanes come from new data, others from old.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic idle_inputs();
    we = 1'b0; waddr = 4'd0; wdata = 32'd0; wbe = 4'd0;
    re0 = 1'b0; re1 = 1'b0; ra0 = 4'd0; ra1 = 4'd0; clr_req = 1'b0;
  endtask

  task automatic write1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    model[a] = merge(model[a], d, be);
    tick();
    we = 1'b0; wbe = 4'd0;
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk({tag, "_rd0"}, rd0, 32'd0);
    chk({tag, "_rd1"}, rd1, 32'd0);
    chk({tag, "_rvalid0"}, {31'd0, rvalid0}, 32'd0);
    chk({tag, "_rvalid1"}, {31'd0, rvalid1}, 32'd0);
    chk({tag, "_rperr0"}, {31'd0, rperr0}, 32'd0);
    chk({tag, "_rperr1"}, {31'd0, rperr1}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_wready"}, {31'd0, wready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    idle_inputs();

    // Reset, with requests present that must be discarded.
    reset = 1'b1; we = 1'b1; wbe = 4'hF; wdata = 32'hFFFF_FFFF; re0 = 1'b1; re1 = 1'b1;
    clr_req = 1'b1;
    tick();
    tick();
    idle_inputs();
    reset = 1'b0;
    check_quiet_outputs("reset");

    // Full-word write then read on port 0.
    write1(4'd3, 32'hDEAD_BEEF, 4'hF);
    re0 = 1'b1; ra0 = 4'd3;
    tick();
    chk("rd0_addr3", rd0, 32'hDEAD_BEEF);
    chk("rvalid0_addr3", {31'd0, rvalid0}, 32'd1);
    re0 = 1'b0;
    tick();
    chk("rvalid0_drop", {31'd0, rvalid0}, 32'd0);
    chk("rd0_hold", rd0, 32'hDEAD_BEEF);

    // Partial write with same-cycle read on port 1 (write-first bypass).
    write1(4'd5, 32'h1122_3344, 4'hF);
    we = 1'b1; waddr = 4'd5; wdata = 32'hAABB_CCDD; wbe = 4'h5;
    model[5] = merge(model[5], 32'hAABB_CCDD, 4'h5);
    re1 = 1'b1; ra1 = 4'd5;
    tick();
    idle_inputs();
    chk("rd1_bypass_merge", rd1, 32'h11BB_33DD);
    chk("rvalid1_bypass", {31'd0, rvalid1}, 32'd1);

    // Zero byte-enable write leaves the entry alone.
    write1(4'd5, 32'h0000_0000, 4'h0);
    re0 = 1'b1; ra0 = 4'd5;
    tick();
    re0 = 1'b0;
    chk("rd0_wbe0", rd0, 32'h11BB_33DD);

    // Both ports on the same address.
    write1(4'd9, 32'h0000_FFFF, 4'hF);
    re0 = 1'b1; re1 = 1'b1; ra0 = 4'd9; ra1 = 4'd9;
    tick();
    idle_inputs();
    chk("rd0_dual", rd0, 32'h0000_FFFF);
    chk("rd1_dual", rd1, 32'h0000_FFFF);
    chk("rvalid0_dual", {31'd0, rvalid0}, 32'd1);
    chk("rvalid1_dual", {31'd0, rvalid1}, 32'd1);
    last0 = 32'h0000_FFFF;
    last1 = 32'h0000_FFFF;

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1)); waddr = 4'($urandom_range(0, 15));
      wdata = $urandom; wbe = 4'($urandom_range(0, 15));
      re0 = 1'($urandom_range(0, 1)); ra0 = 4'($urandom_range(0, 15));
      re1 = 1'($urandom_range(0, 1)); ra1 = 4'($urandom_range(0, 15));
      if (n % 4 == 0) ra1 = waddr;
      if (we) model[waddr] = merge(model[waddr], wdata, wbe);
      if (re0) last0 = model[ra0];
      if (re1) last1 = model[ra1];
      chk("rnd_wready", {31'd0, wready}, 32'd1);
      tick();
      chk("rnd_rvalid0", {31'd0, rvalid0}, {31'd0, re0});
      chk("rnd_rvalid1", {31'd0, rvalid1}, {31'd0, re1});
      chk("rnd_rd0", rd0, last0);
      chk("rnd_rd1", rd1, last1);
      chk("rnd_rperr0", {31'd0, rperr0}, 32'd0);
      chk("rnd_rperr1", {31'd0, rperr1}, 32'd0);
    end
    idle_inputs();

    // Clear requested together with a write: write lands first, then gets zeroed.
    we = 1'b1; waddr = 4'd4; wdata = 32'hCAFE_F00D; wbe = 4'hF; clr_req = 1'b1;
    model[4] = 32'hCAFE_F00D;
    re1 = 1'b1; ra1 = 4'd4;
    tick();
    chk("clr_wr_first", rd1, 32'hCAFE_F00D);
    for (int k = 0; k < 16; k++) begin
      chk("clr_busy", {31'd0, busy}, 32'd1);
      chk("clr_wready", {31'd0, wready}, 32'd0);
      we = 1'b1; waddr = 4'($urandom_range(0, 15)); wdata = $urandom; wbe = 4'hF;
      clr_req = 1'($urandom_range(0, 1));
      re0 = 1'b1; ra0 = 4'(k);
      re1 = 1'b1; ra1 = 4'((k + 1) % 16);
      exp1 = (k < 15) ? model[k + 1] : 32'd0;
      tick();
      chk("clr_rd0_zeroing", rd0, 32'd0);
      chk("clr_rd1_ahead", rd1, exp1);
    end
    idle_inputs();
    chk("clr_done_busy", {31'd0, busy}, 32'd0);
    chk("clr_done_wready", {31'd0, wready}, 32'd1);
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    for (int i = 0; i < 16; i++) begin
      re0 = 1'b1; ra0 = 4'(i); re1 = 1'b1; ra1 = 4'(15 - i);
      tick();
      chk("clr_read0", rd0, model[i]);
      chk("clr_read1", rd1, model[15 - i]);
    end
    idle_inputs();

    // Reset in the middle of a clear.
    write1(4'd12, 32'h1234_ABCD, 4'hF);
    write1(4'd1, 32'h5555_AAAA, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("mid_clr_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; re0 = 1'b1; ra0 = 4'd12; re1 = 1'b1; ra1 = 4'd1; we = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    check_quiet_outputs("clr_reset");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("reclr_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 16; k++) tick();
    chk("reclr_done", {31'd0, busy}, 32'd0);
    re0 = 1'b1; ra0 = 4'd12; re1 = 1'b1; ra1 = 4'd1;
    tick();
    idle_inputs();
    chk("reset_zero12", rd0, 32'd0);
    chk("reset_zero1", rd1, 32'd0);

    // Corrupt one stored bit behind the write path and read it back.
    write1(4'd2, 32'h1234_5678, 4'hF);
    dut.mem_r[2] = 32'h1234_5679;
`ifdef DMAC_RF_PARITY_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    re0 = 1'b1; ra0 = 4'd2;
    tick();
    idle_inputs();
    chk("perr_rd0", rd0, 32'h1234_5679);
    chk("perr_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("perr_flag", {31'd0, rperr0}, {31'd0, exp_perr});
    tick();
    chk("perr_qualified", {31'd0, rperr0}, 32'd0);
    write1(4'd2, 32'h0F0F_0F0F, 4'hF);
    re0 = 1'b1; ra0 = 4'd2;
    tick();
    idle_inputs();
    chk("perr_rewrite_rd0", rd0, 32'h0F0F_0F0F);
    chk("perr_rewrite_flag", {31'd0, rperr0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_regfile_multi.md
DMAC_REGFILE_MULTI -- requirements
Module: dmac_regfile_multi

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32: entry width in bits, a multiple of 8.
REQ-002 The module SHALL have parameter DEPTH, default 16: entry count, a power of 2, at least 2.
REQ-003 The module SHALL have localparam AW = clog2(DEPTH) and NB = DATA_W/8.
REQ-004 The module SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The module SHALL have port we, input, 1: write request.
REQ-007 The module SHALL have port waddr, input, AW: write address.
REQ-008 The module SHALL have port wdata, input, DATA_W: write data.
REQ-009 The module SHALL have port wbe, input, NB: per-byte write enable.
REQ-010 The module SHALL have port wready, output, 1: write is accepted this cycle; equals !busy.
REQ-011 The module SHALL have ports re0/re1, input, 1: read request for ports 0 and 1.
REQ-012 The module SHALL have ports ra0/ra1, input, AW: read address for ports 0 and 1.
REQ-013 The module SHALL have ports rd0/rd1, output, DATA_W: registered read data.
REQ-014 The module SHALL have ports rvalid0/rvalid1, output, 1: rd0/rd1 is valid this cycle.
REQ-015 The module SHALL have ports rperr0/rperr1, output, 1: parity error flag qualified by rvalid.
REQ-016 The module SHALL have port clr_req, input, 1: request to clear all entries.
REQ-017 The module SHALL have port busy, output, 1: clear sequence in progress.

Function
REQ-018 A write SHALL occur when we && wready: each byte b of entry waddr with wbe[b]=1 takes wdata byte b, and the other bytes hold.
REQ-019 When we=1 and wbe=0, the write SHALL leave the entry unchanged and SHALL NOT be an error.
REQ-020 For each port, when reX=1 at edge N, rdX SHALL present entry raX and rvalidX SHALL be 1 after edge N (latency 1); rvalidX SHALL be 1 for exactly one cycle per request.
REQ-021 When reX=0, rdX SHALL hold its last value and rvalidX SHALL be 0.
REQ-022 A read and a write to the same address in the same cycle SHALL return the merged post-write data (write-first bypass); both ports SHALL do this independently.
REQ-023 Both ports reading the same address in the same cycle SHALL return identical data.
REQ-024 The clear FSM SHALL have states IDLE and CLEAR: clr_req=1 in IDLE moves it to CLEAR and sets cnt=0.
REQ-025 In CLEAR, the FSM SHALL zero entry cnt (with its parity) each cycle and increment cnt; after zeroing entry DEPTH-1 it SHALL return to IDLE.
REQ-026 busy SHALL be 1 for exactly DEPTH cycles per clear.
REQ-027 clr_req in CLEAR SHALL be ignored.
REQ-028 we during busy SHALL be dropped (wready=0); the writer SHALL retry.
REQ-029 Reads SHALL be permitted during CLEAR, and a read of entry cnt in the cycle it is zeroed SHALL return 0 (bypass).
REQ-030 clr_req and an accepted write in the same IDLE cycle SHALL complete the write first; the clear then zeroes that entry.

Reset
REQ-031 While reset=1 at an edge, all entries SHALL be set to 0, rd0/rd1=0, rvalid0/rvalid1=0, rperr0/rperr1=0, state=IDLE, cnt=0, busy=0, and wready SHALL follow !busy.
REQ-032 Reset during CLEAR SHALL abort the sequence and return the FSM to IDLE, with all entries zeroed by the reset itself.
REQ-033 Requests sampled in the same edge as reset=1 SHALL be discarded.

Configuration
REQ-034 The macro DMAC_RF_PARITY_EN SHALL select parity support.
REQ-035 With DMAC_RF_PARITY_EN defined, each entry SHALL store NB even-parity bits computed on the merged write data.
REQ-036 With DMAC_RF_PARITY_EN defined, each read SHALL recompute parity, and rperrX SHALL be 1 together with rvalidX on any mismatch.
REQ-037 With DMAC_RF_PARITY_EN undefined, no parity storage SHALL exist and rperr0/rperr1 SHALL be tied 0; ports are unchanged.

Structure
REQ-038 Package dmac_rf_pkg SHALL hold the default DATA_W/DEPTH constants, the state enum (ST_IDLE, ST_CLEAR), and the byte-parity function.
REQ-039 Sub-module dmac_rf_read_port (registered read, bypass mux, parity check) SHALL be instantiated twice.
REQ-040 Storage, write merge and the clear FSM SHALL reside in the top module.

Verification
REQ-041 The bench SHALL cover: write addr 3 = 0xDEADBEEF with wbe=0xF, then re0 ra0=3 -> rd0=0xDEADBEEF and rvalid0=1 one cycle later.
REQ-042 The bench SHALL cover: addr 5 = 0x11223344, then write 0xAABBCCDD with wbe=0x5 together with re1 ra1=5 -> rd1=0x11BB33DD in the next cycle.
REQ-043 The bench SHALL cover: clr_req with DEPTH=16 -> busy high for exactly 16 cycles, we ignored throughout, then all 16 entries read 0.
REQ-044 The bench SHALL cover: reset asserted at clear cycle 7 -> busy=0, state IDLE, all outputs 0 after the edge, and a new clr_req is accepted afterwards.
REQ-045 The bench SHALL cover: both ports reading addr 9 = 0x0000FFFF -> rd0=rd1=0x0000FFFF with both rvalid set in the same cycle.
REQ-046 The bench SHALL cover, with DMAC_RF_PARITY_EN: force-flip bit 0 of stored entry 2, then read -> rperr0=1; without the macro -> rperr0 stays 0.
